// File: rtl/int2float_pkg.sv
// Mini-float format shared by the int2float encoder and the float2int decoder,
// plus the decoder FSM states and a reference decode function.
package int2float_pkg;

    localparam int INT_W   = 11;
    localparam int EXP_W   = 4;
    localparam int MAN_W   = 3;
    localparam int SAT_EXP = INT_W - MAN_W;

    // Exponent-width copy of SAT_EXP so compares stay width-matched.
    localparam logic [EXP_W-1:0] SAT_E = EXP_W'(SAT_EXP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } f2i_state_t;

    function automatic logic [INT_W-1:0] f2i_ref(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] m
    );
        logic [INT_W-1:0] base;
        base = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, m};
        if (e == '0)
            f2i_ref = INT_W'(m);
        else if (e > SAT_E)
            f2i_ref = '1;
        else
            f2i_ref = base << (e - 1'b1);
    endfunction

endpackage

// File: rtl/float2int_untilsat_shift_core.sv
// Significand/count registers for the one-bit-per-cycle decoder shifter.
module f2i_shift_core
    import int2float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [MAN_W-1:0] man_in,
    output logic [INT_W-1:0] sig,
    output logic             load_zero,
    output logic             last_shift
);

    logic [INT_W-1:0] sig_q, sig_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;

    // E<=1 needs no shifting at all; the top uses this to skip SHIFT.
    assign load_zero  = (exp_in <= EXP_W'(1));
    assign last_shift = shift_en && (cnt_q == EXP_W'(1));
    assign sig        = sig_q;

    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (load) begin
            sig_d = {{(INT_W-MAN_W-1){1'b0}}, (exp_in != '0), man_in};
            cnt_d = (exp_in == '0) ? '0 : exp_in - 1'b1;
        end else if (shift_en) begin
            sig_d = sig_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Significand is pure data; only the counter is reset.
    always_ff @(posedge clk) begin
        sig_q <= sig_d;
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    a_no_msb_loss: assert property (@(posedge clk) disable iff (rst)
        shift_en |-> !sig_q[INT_W-1]);

endmodule

// File: rtl/float2int_untilsat.sv
// Iterative mini-float to unsigned integer decoder with saturation and
// valid/ready handshakes on both sides.
module float2int_untilsat
    import int2float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             out_sat
);

    f2i_state_t       state_q, state_d;
    logic             sat_q, sat_d;
    logic             accept;
    logic             shift_en;
    logic             load_zero;
    logic             last_shift;
    logic [INT_W-1:0] sig;

    assign accept   = in_valid && (state_q == IDLE);
    assign shift_en = (state_q == SHIFT);

    f2i_shift_core u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift_en   (shift_en),
        .exp_in     (in_exp),
        .man_in     (in_man),
        .sig        (sig),
        .load_zero  (load_zero),
        .last_shift (last_shift)
    );

    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sat_d   = (in_exp > SAT_E);
                    state_d = ((in_exp > SAT_E) || load_zero) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= sat_d;
        end
    end

    // Outputs are forced to zero outside DONE so stale data never leaks.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sat   = (state_q == DONE) && sat_q;
    assign out_int   = (state_q != DONE) ? '0 : (sat_q ? '1 : sig);

endmodule

// File: tb/tb_float2int_untilsat.sv
// Randomized self-checking bench for float2int_untilsat against an
// arithmetic model of the mini-float decode rule.
module tb_float2int_untilsat;
    import int2float_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] out_int;
    logic             out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    float2int_untilsat dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_val(input int e, input int m);
        if (e == 0) return m;
        if (e > INT_W - MAN_W) return (1 << INT_W) - 1;
        return (8 + m) * (1 << (e - 1));
    endfunction

    function automatic int model_lat(input int e);
        return (e <= 1 || e > INT_W - MAN_W) ? 1 : e;
    endfunction

    // One conversion starting at a negedge with the DUT idle.
    task automatic run_conv(input int e, input int m, input int stall, input int unsigned exp_val);
        int lat;
        logic [INT_W-1:0] held;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_exp   = EXP_W'(e);
        in_man   = MAN_W'(m);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_exp   = EXP_W'($urandom);
        in_man   = MAN_W'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat_e%0d", e), lat, model_lat(e));
        chk($sformatf("int_e%0d_m%0d", e, m), out_int, exp_val);
        chk($sformatf("sat_e%0d", e), out_sat, (e > INT_W - MAN_W) ? 1 : 0);
        held = out_int;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_exp   = EXP_W'($urandom);
            in_man   = MAN_W'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_int", out_int, held);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_int", out_int, 0);
        chk("post_ready", in_ready, 1);
    endtask

    initial begin
        int msb;
        int unsigned v, rt;
        rst = 1'b1; in_valid = 1'b0; in_exp = '0; in_man = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_int", out_int, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_ready", in_ready, 1);

        run_conv(0, 5, 0, 5);
        run_conv(1, 0, 0, 8);
        run_conv(4, 3, 0, 88);
        run_conv(8, 7, 0, 1920);
        run_conv(9, 0, 0, 2047);
        run_conv(15, 7, 0, 2047);
        run_conv(2, 1, 3, 18);

        // Reset in the middle of a long shift.
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_exp = 4'd6; in_man = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_int", out_int, 0);
        chk("midrst_sat", out_sat, 0);
        chk("midrst_ready", in_ready, 1);
        run_conv(3, 2, 0, 40);

        // Every {E,M} pair with random backpressure.
        for (int e = 0; e < 16; e++)
            for (int m = 0; m < 8; m++) begin
                chk("pkg_ref", f2i_ref(EXP_W'(e), MAN_W'(m)), model_val(e, m));
                run_conv(e, m, $urandom_range(0, 2), model_val(e, m));
            end

        // Random pairs.
        for (int k = 0; k < 100; k++) begin
            int e, m;
            e = $urandom_range(0, 15);
            m = $urandom_range(0, 7);
            run_conv(e, m, $urandom_range(0, 3), model_val(e, m));
        end

        // Round trip: encoder keeps the top four significant bits.
        for (int unsigned x = 0; x < (1 << INT_W); x++) begin
            int e, m;
            if (x < 8) begin
                e = 0; m = x; rt = x;
            end else begin
                msb = 0;
                v = x;
                while (v > 1) begin v = v >> 1; msb++; end
                e  = msb - 2;
                m  = (x >> (msb - 3)) & 7;
                rt = (x >> (msb - 3)) << (msb - 3);
            end
            run_conv(e, m, 0, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
